// File: rtl/vga_fb_pkg.sv
// Shared types and defaults for the VGA frame-buffer SDRAM arbiter.
package vga_fb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        CMD  = 2'd2,
        WAIT = 2'd3
    } arbState_t;

    typedef enum logic {
        PATH_RD = 1'b0,
        PATH_WR = 1'b1
    } path_t;

    localparam int DEF_BURST_LEN  = 64;
    localparam int DEF_FIFO_DEPTH = 512;
    localparam int DEF_RD_URGENT  = 384;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Per-path frame offset counter: burst length clamp, wrap at frame size,
// and deferred frame-start clear while the path owns the memory port.
module vga_fb_addr_gen
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [ADDR_W-1:0] iFrameSize,
    input  logic              iFrameStart,
    input  logic              iActive,
    input  logic              iDone,
    output logic [ADDR_W-1:0] oOffset,
    output logic [7:0]        oLen,
    output logic              oWrap
);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] remain;
    logic [ADDR_W-1:0] nextOff;
    logic              pending;
    logic              reachEnd;

    // An offset beyond a freshly shrunk frame yields len 0 (never eligible)
    // until the next frame start clears it.
    always_comb begin
        remain   = (offset < iFrameSize) ? iFrameSize - offset : '0;
        oLen     = (remain >= ADDR_W'(BURST_LEN)) ? 8'(BURST_LEN) : remain[7:0];
        nextOff  = offset + ADDR_W'(oLen);
        reachEnd = (nextOff >= iFrameSize);
        oWrap    = iDone && !(pending || iFrameStart) && reachEnd;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            offset  <= '0;
            pending <= 1'b0;
        end else if (iDone) begin
            pending <= 1'b0;
            offset  <= (pending || iFrameStart || reachEnd) ? '0 : nextOff;
        end else if (iFrameStart) begin
            if (iActive) begin
                pending <= 1'b1;
            end else begin
                offset <= '0;
            end
        end
    end

    assign oOffset = offset;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Camera-write / VGA-read SDRAM burst arbiter with frame-relative addressing.
// Optional ping-pong frame buffers: define VGA_FB_DOUBLE_BUFFER_EN.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int LVL_W      = 10,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int RD_URGENT  = DEF_RD_URGENT,
    parameter int WR_BASE    = 0,
    parameter int RD_BASE    = 0
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [15:0]       iVideo_W,
    input  logic [15:0]       iVideo_H,
    input  logic [LVL_W-1:0]  iWr_Level,
    input  logic              iWr_Frame_Start,
    input  logic [LVL_W-1:0]  iRd_Free,
    input  logic              iRd_Frame_Start,
    output logic              oMem_Cmd_Valid,
    input  logic              iMem_Cmd_Ready,
    output logic              oMem_Cmd_Write,
    output logic [ADDR_W-1:0] oMem_Addr,
    output logic [7:0]        oMem_Len,
    input  logic              iMem_Done,
    output logic              oBusy,
    output logic              oWr_Overrun
);

    arbState_t         state, stateNext;
    path_t             grant, grantNext, rrNext;
    logic [ADDR_W-1:0] frameSize;
    logic [ADDR_W-1:0] rdOff, wrOff, rdBase, wrBase;
    logic [7:0]        rdLen, wrLen;
    logic              rdElig, wrElig, rdUrgent, portOwned;
`ifdef VGA_FB_DOUBLE_BUFFER_EN
    logic              wrWrap;
`endif

    assign portOwned = (state == CMD) || (state == WAIT);
    assign rdElig    = (rdLen != 8'd0) && (32'(iRd_Free) >= 32'(rdLen));
    assign wrElig    = (wrLen != 8'd0) && (32'(iWr_Level) >= 32'(wrLen));
    assign rdUrgent  = rdElig && (32'(iRd_Free) > 32'(RD_URGENT));

    vga_fb_addr_gen #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) uRdAddr (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iFrameSize  (frameSize),
        .iFrameStart (iRd_Frame_Start),
        .iActive     (portOwned && (grant == PATH_RD)),
        .iDone       ((state == WAIT) && iMem_Done && (grant == PATH_RD)),
        .oOffset     (rdOff),
        .oLen        (rdLen),
        .oWrap       ()
    );

    vga_fb_addr_gen #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) uWrAddr (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iFrameSize  (frameSize),
        .iFrameStart (iWr_Frame_Start),
        .iActive     (portOwned && (grant == PATH_WR)),
        .iDone       ((state == WAIT) && iMem_Done && (grant == PATH_WR)),
        .oOffset     (wrOff),
        .oLen        (wrLen),
`ifdef VGA_FB_DOUBLE_BUFFER_EN
        .oWrap       (wrWrap)
`else
        .oWrap       ()
`endif
    );

`ifdef VGA_FB_DOUBLE_BUFFER_EN
    logic wrBank, doneBank, rdBank, wrFrameDone;

    // Bank flips only once a full write frame has landed, so the reader
    // always latches a complete frame at its own frame start.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wrBank      <= 1'b0;
            doneBank    <= 1'b0;
            rdBank      <= 1'b0;
            wrFrameDone <= 1'b0;
        end else begin
            if (wrWrap) begin
                wrFrameDone <= 1'b1;
                doneBank    <= wrBank;
            end
            if (iWr_Frame_Start && (wrFrameDone || wrWrap)) begin
                wrBank      <= ~wrBank;
                wrFrameDone <= 1'b0;
            end
            if (iRd_Frame_Start) begin
                rdBank <= wrWrap ? wrBank : doneBank;
            end
        end
    end

    assign wrBase = ADDR_W'(WR_BASE) + (wrBank ? frameSize : '0);
    assign rdBase = ADDR_W'(WR_BASE) + (rdBank ? frameSize : '0);
`else
    assign wrBase = ADDR_W'(WR_BASE);
    assign rdBase = ADDR_W'(RD_BASE);
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        grantNext = grant;
        case (state)
            IDLE: if (rdElig || wrElig) stateNext = ARB;
            ARB: begin
                stateNext = CMD;
                if (rdUrgent) begin
                    grantNext = PATH_RD;
                end else if (rdElig && wrElig) begin
                    grantNext = rrNext;
                end else if (rdElig) begin
                    grantNext = PATH_RD;
                end else if (wrElig) begin
                    grantNext = PATH_WR;
                end else begin
                    stateNext = IDLE;
                end
            end
            CMD:  if (iMem_Cmd_Ready) stateNext = WAIT;
            WAIT: if (iMem_Done) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            grant          <= PATH_RD;
            rrNext         <= PATH_RD;
            oMem_Cmd_Write <= 1'b0;
            oMem_Addr      <= '0;
            oMem_Len       <= '0;
            frameSize      <= ADDR_W'(32'(iVideo_W) * 32'(iVideo_H));
            oWr_Overrun    <= 1'b0;
        end else begin
            grant <= grantNext;
            if ((state == ARB) && (stateNext == CMD)) begin
                oMem_Cmd_Write <= (grantNext == PATH_WR);
                oMem_Addr      <= (grantNext == PATH_WR) ? wrBase + wrOff : rdBase + rdOff;
                oMem_Len       <= (grantNext == PATH_WR) ? wrLen : rdLen;
            end
            if ((state == WAIT) && iMem_Done) begin
                rrNext <= (grant == PATH_RD) ? PATH_WR : PATH_RD;
            end
            if (iWr_Frame_Start || iRd_Frame_Start) begin
                frameSize <= ADDR_W'(32'(iVideo_W) * 32'(iVideo_H));
            end
            if (32'(iWr_Level) == 32'(FIFO_DEPTH)) begin
                oWr_Overrun <= 1'b1;
            end
        end
    end

    assign oMem_Cmd_Valid = (state == CMD);
    assign oBusy          = portOwned;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter (default single-buffer build).
module tb_vga_fb_arbiter;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [15:0] iVideo_W, iVideo_H;
    logic [9:0]  iWr_Level, iRd_Free;
    logic        iWr_Frame_Start, iRd_Frame_Start;
    logic        oMem_Cmd_Valid, iMem_Cmd_Ready, oMem_Cmd_Write;
    logic [23:0] oMem_Addr;
    logic [7:0]  oMem_Len;
    logic        iMem_Done, oBusy, oWr_Overrun;

    int nChecks = 0;
    int nPass   = 0;

    always #5 iCLK = ~iCLK;

    vga_fb_arbiter #(.ADDR_W(24), .LVL_W(10), .BURST_LEN(64)) dut (
        .iCLK            (iCLK),
        .iRST            (iRST),
        .iVideo_W        (iVideo_W),
        .iVideo_H        (iVideo_H),
        .iWr_Level       (iWr_Level),
        .iWr_Frame_Start (iWr_Frame_Start),
        .iRd_Free        (iRd_Free),
        .iRd_Frame_Start (iRd_Frame_Start),
        .oMem_Cmd_Valid  (oMem_Cmd_Valid),
        .iMem_Cmd_Ready  (iMem_Cmd_Ready),
        .oMem_Cmd_Write  (oMem_Cmd_Write),
        .oMem_Addr       (oMem_Addr),
        .oMem_Len        (oMem_Len),
        .iMem_Done       (iMem_Done),
        .oBusy           (oBusy),
        .oWr_Overrun     (oWr_Overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Serve one burst: wait for the command, optionally stall ready, accept,
    // optionally pulse the read frame start in WAIT, then signal done.
    task automatic doBurst(input string tag, input logic expW, input int expA,
                           input int expL, input int stall, input bit rdFs);
        int n = 0;
        while (!oMem_Cmd_Valid && n < 20) begin
            @(negedge iCLK);
            n++;
        end
        chk({tag, "_valid"}, 32'(oMem_Cmd_Valid), 32'd1);
        chk({tag, "_write"}, 32'(oMem_Cmd_Write), 32'(expW));
        chk({tag, "_addr"},  32'(oMem_Addr), 32'(expA));
        chk({tag, "_len"},   32'(oMem_Len), 32'(expL));
        for (int i = 0; i < stall; i++) begin
            @(negedge iCLK);
            chk({tag, "_holdValid"}, 32'(oMem_Cmd_Valid), 32'd1);
            chk({tag, "_holdWrite"}, 32'(oMem_Cmd_Write), 32'(expW));
            chk({tag, "_holdAddr"},  32'(oMem_Addr), 32'(expA));
            chk({tag, "_holdLen"},   32'(oMem_Len), 32'(expL));
        end
        iMem_Cmd_Ready = 1'b1;
        @(negedge iCLK);
        iMem_Cmd_Ready = 1'b0;
        chk({tag, "_busy"}, 32'(oBusy), 32'd1);
        if (rdFs) begin
            iRd_Frame_Start = 1'b1;
            @(negedge iCLK);
            iRd_Frame_Start = 1'b0;
        end
        @(negedge iCLK);
        iMem_Done = 1'b1;
        @(negedge iCLK);
        iMem_Done = 1'b0;
        chk({tag, "_idle"}, 32'(oBusy), 32'd0);
    endtask

    initial begin
        bit sawValid;
        iRST = 1'b1;
        iVideo_W = 16'd640;
        iVideo_H = 16'd480;
        iWr_Level = '0;
        iRd_Free = '0;
        iWr_Frame_Start = 1'b0;
        iRd_Frame_Start = 1'b0;
        iMem_Cmd_Ready = 1'b0;
        iMem_Done = 1'b0;
        repeat (3) @(negedge iCLK);
        chk("rstValid",   32'(oMem_Cmd_Valid), 32'd0);
        chk("rstBusy",    32'(oBusy), 32'd0);
        chk("rstOverrun", 32'(oWr_Overrun), 32'd0);
        chk("rstAddr",    32'(oMem_Addr), 32'd0);
        chk("rstLen",     32'(oMem_Len), 32'd0);
        chk("rstWrite",   32'(oMem_Cmd_Write), 32'd0);
        iRST = 1'b0;

        // Read-only traffic
        iRd_Free = 10'd100;
        doBurst("rd0", 1'b0, 0,   64, 0, 1'b0);
        doBurst("rd1", 1'b0, 64,  64, 0, 1'b0);
        doBurst("rd2", 1'b0, 128, 64, 0, 1'b0);

        // Both eligible: last grant was read, so write goes first
        iWr_Level = 10'd100;
        doBurst("alt0W", 1'b1, 0,   64, 0, 1'b0);
        doBurst("alt1R", 1'b0, 192, 64, 0, 1'b0);
        doBurst("alt2W", 1'b1, 64,  64, 0, 1'b0);
        doBurst("alt3R", 1'b0, 256, 64, 0, 1'b0);

        // Urgent read wins every time
        iRd_Free = 10'd400;
        doBurst("urg0", 1'b0, 320, 64, 0, 1'b0);
        doBurst("urg1", 1'b0, 384, 64, 0, 1'b0);
        doBurst("urg2", 1'b0, 448, 64, 0, 1'b0);

        doBurst("stall", 1'b0, 512, 64, 5, 1'b0);

        // Frame start in WAIT: offset clears at done instead of advancing
        doBurst("fsWait", 1'b0, 576, 64, 0, 1'b1);
        doBurst("fsNext", 1'b0, 0,   64, 0, 1'b0);

        // Wrap on a 100-word frame
        iRd_Free = '0;
        iWr_Level = '0;
        iVideo_W = 16'd100;
        iVideo_H = 16'd1;
        iRd_Frame_Start = 1'b1;
        @(negedge iCLK);
        iRd_Frame_Start = 1'b0;
        iRd_Free = 10'd100;
        doBurst("wrap0", 1'b0, 0,  64, 0, 1'b0);
        doBurst("wrap1", 1'b0, 64, 36, 0, 1'b0);
        doBurst("wrap2", 1'b0, 0,  64, 0, 1'b0);
        iRd_Free = '0;

        // Zero frame size: nothing is ever eligible
        iVideo_W = 16'd0;
        iRd_Frame_Start = 1'b1;
        iWr_Frame_Start = 1'b1;
        @(negedge iCLK);
        iRd_Frame_Start = 1'b0;
        iWr_Frame_Start = 1'b0;
        iRd_Free = 10'd400;
        iWr_Level = 10'd300;
        sawValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge iCLK);
            if (oMem_Cmd_Valid || oBusy) sawValid = 1'b1;
        end
        chk("fsZeroNoGrant", 32'(sawValid), 32'd0);
        chk("preOverrun", 32'(oWr_Overrun), 32'd0);

        // Sticky overrun
        iWr_Level = 10'd512;
        @(negedge iCLK);
        iWr_Level = 10'd0;
        chk("overrunSet", 32'(oWr_Overrun), 32'd1);
        repeat (3) @(negedge iCLK);
        chk("overrunSticky", 32'(oWr_Overrun), 32'd1);
        iRST = 1'b1;
        @(negedge iCLK);
        chk("overrunCleared", 32'(oWr_Overrun), 32'd0);
        chk("rst2Valid", 32'(oMem_Cmd_Valid), 32'd0);
        iRST = 1'b0;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d checks expected completion", nChecks);
        $fatal(1);
    end

endmodule
